// File: rtl/reg_file_64x32_if.sv
// Operand/writeback bus between the LEGv8 datapath and its register file.
// The datapath side drives indices and write data; the register file returns operands.
interface reg_file_64x32_if #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 5
);
  logic [ADDR_W-1:0] ReadRegister1;
  logic [ADDR_W-1:0] ReadRegister2;
  logic [ADDR_W-1:0] WriteRegister;
  logic [DATA_W-1:0] WriteData;
  logic              RegWrite;
  logic [DATA_W-1:0] ReadData1;
  logic [DATA_W-1:0] ReadData2;

  modport master (
    output ReadRegister1, ReadRegister2, WriteRegister, WriteData, RegWrite,
    input  ReadData1, ReadData2
  );

  modport slave (
    input  ReadRegister1, ReadRegister2, WriteRegister, WriteData, RegWrite,
    output ReadData1, ReadData2
  );
endinterface

// File: rtl/reg_file_64x32.sv
// 32 x 64-bit LEGv8 register file: two combinational read ports with same-cycle
// write bypass, one synchronous write port, XZR hardwired to zero.
module reg_file_64x32 #(
  parameter int DATA_W   = 64,
  parameter int ADDR_W   = 5,
  parameter int NUM_REGS = 32,
  parameter int ZERO_REG = 31
) (
  input  logic             clk,
  input  logic             reset,
  reg_file_64x32_if.slave  bus
);

  logic [NUM_REGS-1:0] wr_dec;
  logic [DATA_W-1:0]   reg_val [NUM_REGS];
  logic [DATA_W-1:0]   rd_data [2];

  always_comb begin
    wr_dec = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      wr_dec[i] = bus.RegWrite && (bus.WriteRegister == ADDR_W'(i)) && (i != ZERO_REG);
    end
  end

  // XZR has no storage; every other index gets a flop bank cleared by the async reset.
  for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg
    if (g == ZERO_REG) begin : g_zero
      assign reg_val[g] = '0;
    end else begin : g_flop
      logic [DATA_W-1:0] data_q;
      logic [DATA_W-1:0] data_d;

      assign data_d = wr_dec[g] ? bus.WriteData : data_q;

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          data_q <= '0;
        end else begin
          data_q <= data_d;
        end
      end

      assign reg_val[g] = data_q;
    end
  end

  // Per-port 32:1 mux as a tree of 2:1 stages, LSB of the index selecting first.
  for (genvar p = 0; p < 2; p++) begin : g_port
    logic [ADDR_W-1:0] sel;
    logic              byp;

    assign sel = (p == 0) ? bus.ReadRegister1 : bus.ReadRegister2;

    for (genvar l = 0; l < ADDR_W; l++) begin : g_lvl
      logic [DATA_W-1:0] v [NUM_REGS >> (l + 1)];
      for (genvar j = 0; j < (NUM_REGS >> (l + 1)); j++) begin : g_mux
        if (l == 0) begin : g_leaf
          assign v[j] = sel[l] ? reg_val[2*j+1] : reg_val[2*j];
        end else begin : g_inner
          assign v[j] = sel[l] ? g_lvl[l-1].v[2*j+1] : g_lvl[l-1].v[2*j];
        end
      end
    end

    assign byp = bus.RegWrite && (bus.WriteRegister == sel) && (sel != ADDR_W'(ZERO_REG));

    assign rd_data[p] = reset ? '0 :
                        byp   ? bus.WriteData :
                                g_lvl[ADDR_W-1].v[0];
  end

  assign bus.ReadData1 = rd_data[0];
  assign bus.ReadData2 = rd_data[1];

endmodule

// File: tb/tb_reg_file_64x32.sv
// Self-checking bench for reg_file_64x32: directed vector table, hand-written
// reset/XZR/collision sequences, and randomized traffic against an array model.
module tb_reg_file_64x32;

  logic clk;
  logic reset;

  reg_file_64x32_if #(.DATA_W(64), .ADDR_W(5)) bif ();

  reg_file_64x32 dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk;
  int n_fail;
  logic [63:0] model [32];

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [63:0] wd;
    logic [4:0]  ra1;
    logic [4:0]  ra2;
    logic [63:0] e1;
    logic [63:0] e2;
  } vec_t;

  vec_t vt [9];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < 32; i++) model[i] = 64'h0;
  endtask

  // Expected read value from the architectural rules.
  function automatic logic [63:0] exp_rd(input logic [4:0] ra);
    if (reset) return 64'h0;
    if (ra == 5'd31) return 64'h0;
    if (bif.RegWrite && bif.WriteRegister == ra) return bif.WriteData;
    return model[ra];
  endfunction

  // One rising edge (model updated with the write it performs), returns at the falling edge.
  task automatic cycle();
    @(posedge clk);
    if (!reset && bif.RegWrite && bif.WriteRegister != 5'd31)
      model[bif.WriteRegister] = bif.WriteData;
    @(negedge clk);
  endtask

  task automatic drive(input logic we, input logic [4:0] wa, input logic [63:0] wd,
                       input logic [4:0] ra1, input logic [4:0] ra2);
    bif.RegWrite      = we;
    bif.WriteRegister = wa;
    bif.WriteData     = wd;
    bif.ReadRegister1 = ra1;
    bif.ReadRegister2 = ra2;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [64:0] alu_sum;
    logic [63:0] alu_res;
    n_chk  = 0;
    n_fail = 0;
    clear_model();

    drive(1'b0, 5'd0, 64'h0, 5'd0, 5'd1);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    #1 check("reset_hold_rd1", bif.ReadData1, 64'h0);
    check("reset_hold_rd2", bif.ReadData2, 64'h0);
    reset = 1'b0;

    // Async reset between edges must clear the preloaded X5 before the next edge.
    drive(1'b1, 5'd5, 64'hDEAD_BEEF, 5'd5, 5'd5);
    cycle();
    drive(1'b0, 5'd0, 64'h0, 5'd5, 5'd6);
    #1 check("preload_x5", bif.ReadData1, 64'hDEAD_BEEF);
    #1 reset = 1'b1;
    clear_model();
    #1 check("async_reset_x5", bif.ReadData1, 64'h0);
    cycle();
    reset = 1'b0;
    for (int i = 0; i < 31; i++) begin
      bif.ReadRegister1 = 5'(i);
      bif.ReadRegister2 = 5'(30 - i);
      #1 check($sformatf("post_reset_rd1_x%0d", i), bif.ReadData1, 64'h0);
      check($sformatf("post_reset_rd2_x%0d", 30 - i), bif.ReadData2, 64'h0);
    end

    // Write/readback sweep.
    for (int i = 0; i < 31; i++) begin
      drive(1'b1, 5'(i), 64'h0101_0101_0101_0101 * 64'(i), 5'd31, 5'd31);
      cycle();
    end
    drive(1'b0, 5'd9, 64'hFFFF_FFFF_FFFF_FFFF, 5'd0, 5'd0);
    cycle();
    for (int i = 0; i < 31; i++) begin
      bif.ReadRegister1 = 5'(i);
      bif.ReadRegister2 = 5'(i);
      #1 check($sformatf("sweep_rd1_x%0d", i), bif.ReadData1, 64'h0101_0101_0101_0101 * 64'(i));
      check($sformatf("sweep_rd2_x%0d", i), bif.ReadData2, 64'h0101_0101_0101_0101 * 64'(i));
    end

    // Directed table, applied from a clean reset.
    vt[0] = '{1'b1, 5'd7,  64'h8000_0000_0000_0001, 5'd7,  5'd7,  64'h8000_0000_0000_0001, 64'h8000_0000_0000_0001};
    vt[1] = '{1'b0, 5'd7,  64'hFFFF_FFFF_FFFF_FFFF, 5'd7,  5'd7,  64'h8000_0000_0000_0001, 64'h8000_0000_0000_0001};
    vt[2] = '{1'b1, 5'd31, 64'h1234,                5'd31, 5'd30, 64'h0,                   64'h0};
    vt[3] = '{1'b0, 5'd31, 64'h1234,                5'd31, 5'd30, 64'h0,                   64'h0};
    vt[4] = '{1'b1, 5'd1,  64'h1,                   5'd1,  5'd7,  64'h1,                   64'h8000_0000_0000_0001};
    vt[5] = '{1'b1, 5'd2,  64'h1,                   5'd1,  5'd2,  64'h1,                   64'h1};
    vt[6] = '{1'b0, 5'd2,  64'h5,                   5'd2,  5'd0,  64'h1,                   64'h0};
    vt[7] = '{1'b1, 5'd0,  64'hFFFF_FFFF_FFFF_FFFF, 5'd0,  5'd31, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0};
    vt[8] = '{1'b0, 5'd0,  64'h0,                   5'd0,  5'd0,  64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF};
    #1 reset = 1'b1;
    clear_model();
    cycle();
    reset = 1'b0;
    for (int i = 0; i < 9; i++) begin
      drive(vt[i].we, vt[i].wa, vt[i].wd, vt[i].ra1, vt[i].ra2);
      #1 check($sformatf("vec%0d_rd1", i), bif.ReadData1, vt[i].e1);
      check($sformatf("vec%0d_rd2", i), bif.ReadData2, vt[i].e2);
      cycle();
    end

    // ALU add of X1 + X2 (cntrl 010).
    drive(1'b0, 5'd0, 64'h0, 5'd1, 5'd2);
    #1 alu_sum = {1'b0, bif.ReadData1} + {1'b0, bif.ReadData2};
    alu_res = alu_sum[63:0];
    check("alu_result", alu_res, 64'h2);
    check("alu_zero", 64'(alu_res == 64'h0), 64'h0);
    check("alu_negative", 64'(alu_res[63]), 64'h0);
    check("alu_carry", 64'(alu_sum[64]), 64'h0);

    // Reset colliding with a write, with bypass addressed.
    drive(1'b1, 5'd3, 64'hAAAA, 5'd3, 5'd3);
    reset = 1'b1;
    clear_model();
    #1 check("collide_bypass_suppressed", bif.ReadData1, 64'h0);
    cycle();
    reset = 1'b0;
    bif.RegWrite = 1'b0;
    #1 check("collide_x3_rd1", bif.ReadData1, 64'h0);
    check("collide_x3_rd2", bif.ReadData2, 64'h0);

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      logic [4:0] wa;
      reset = 1'b0;
      wa = 5'($urandom_range(0, 31));
      drive(1'($urandom_range(0, 1)), wa, {$urandom, $urandom},
            ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31)),
            ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31)));
      if ($urandom_range(0, 63) == 0) begin
        reset = 1'b1;
        clear_model();
      end
      #1 check($sformatf("rand%0d_rd1", n), bif.ReadData1, exp_rd(bif.ReadRegister1));
      check($sformatf("rand%0d_rd2", n), bif.ReadData2, exp_rd(bif.ReadRegister2));
      cycle();
    end
    reset = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
